// File: rtl/job_pkg.sv
// Shared types and defaults for the job launcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package job_pkg;

  // Launcher FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } state_e;

  localparam int unsigned JOB_W_DEF   = 8;
  localparam int unsigned LAT_W_DEF   = 16;
  localparam int unsigned GAP_CYC_DEF = 2;
  localparam int unsigned TMO_CYC_DEF = 1024;

endpackage

// File: rtl/job_launcher_lat_counter.sv
// Saturating up-counter with synchronous clear and load; clear wins over load, load over increment.
// Latency: 1 cycle from control input to cnt_o.
// Backpressure: none; increments stop at the all-ones value instead of wrapping.
module lat_counter
  import job_pkg::*;
#(
  parameter int unsigned W = LAT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, load, or saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/job_launcher.sv
// Batch job launcher: issues num_jobs start pulses, one at a time, waiting for done between them.
// Latency: job_start 1 cycle after go accept; all_done 2 cycles after the last accepted done.
// Backpressure: a done held high is absorbed by the GAP low-wait; go while busy is dropped. Watchdog: JOB_LAUNCHER_TMO_EN.
module job_launcher
  import job_pkg::*;
#(
  parameter int unsigned JOB_W   = JOB_W_DEF,
  parameter int unsigned LAT_W   = LAT_W_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [JOB_W-1:0] num_jobs,
  output logic             job_start,
  input  logic             job_done,
  output logic             busy,
  output logic             all_done,
  output logic [JOB_W-1:0] jobs_completed,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic             err_timeout
);

`ifdef JOB_LAUNCHER_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [LAT_W-1:0] TMO_LIM  = LAT_W'(TMO_CYC);
  localparam logic [LAT_W-1:0] GAP_LAST = LAT_W'(GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [JOB_W-1:0] num_q;
  logic [JOB_W-1:0] done_cnt_q;
  logic [JOB_W-1:0] done_nxt;
  logic [LAT_W-1:0] last_q;
  logic [LAT_W-1:0] max_q;
  logic             busy_q;
  logic             all_done_q;

  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] gap_cnt;
  logic             lat_ld, lat_inc;
  logic             gap_clr, gap_inc;
  logic             job_end;
  logic             go_acc;
  logic             tmo_hit;

  assign go_acc   = (state_q == IDLE) && go;
  assign done_nxt = done_cnt_q + JOB_W'(1);
  // Constant-false when the watchdog is compiled out, so WAIT never times out.
  assign tmo_hit  = TMO_EN && (lat_cnt == TMO_LIM);

  // Cycles since job_start: loads 1 on the start cycle, counts up while waiting.
  lat_counter #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (1'b0),
    .ld_i     (lat_ld),
    .ld_val_i (LAT_W'(1)),
    .inc_i    (lat_inc),
    .cnt_o    (lat_cnt)
  );

  // Consecutive done-low cycles spent in GAP; restarts whenever done is seen high.
  lat_counter #(.W(LAT_W)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (gap_clr),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (gap_inc),
    .cnt_o    (gap_cnt)
  );

  // Next-state and counter controls.
  always_comb begin
    state_d = state_q;
    lat_ld  = 1'b0;
    lat_inc = 1'b0;
    gap_clr = 1'b0;
    gap_inc = 1'b0;
    job_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = (num_jobs == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        // done seen in this cycle belongs to the previous job and is ignored.
        lat_ld  = 1'b1;
        gap_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        lat_inc = 1'b1;
        gap_clr = 1'b1;
        if (job_done || tmo_hit) begin
          job_end = 1'b1;
          state_d = (done_nxt == num_q) ? FINISH : GAP;
        end
      end
      GAP: begin
        if (job_done) begin
          gap_clr = 1'b1;
        end else if (gap_cnt == GAP_LAST) begin
          state_d = ISSUE;
        end else begin
          gap_inc = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Batch capture, completion count, latency results, busy and all_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_q      <= '0;
      done_cnt_q <= '0;
      last_q     <= '0;
      max_q      <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      all_done_q <= (state_q == FINISH);
      if (go_acc) begin
        num_q      <= num_jobs;
        done_cnt_q <= '0;
        max_q      <= '0;
        busy_q     <= 1'b1;
      end else if (state_q == FINISH) begin
        busy_q <= 1'b0;
      end
      if (job_end) begin
        last_q     <= lat_cnt;
        done_cnt_q <= done_nxt;
        if (lat_cnt >= max_q) begin
          max_q <= lat_cnt;
        end
      end
    end
  end

`ifdef JOB_LAUNCHER_TMO_EN
  logic err_q;

  // Sticky watchdog flag: set when a job times out, cleared by the next accepted go.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (go_acc) begin
      err_q <= 1'b0;
    end else if ((state_q == WAIT) && tmo_hit && !job_done) begin
      err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign job_start      = (state_q == ISSUE);
  assign busy           = busy_q;
  assign all_done       = all_done_q;
  assign jobs_completed = done_cnt_q;
  assign last_latency   = last_q;
  assign max_latency    = max_q;

endmodule

// File: tb/tb_job_launcher.sv
// Randomized scoreboard bench for job_launcher with a model worker of configurable delay/hold.
// Expected start/all_done cycles and result values are derived from the batch rules with plain arithmetic.
// A negedge monitor pops the scoreboard on every job_start/all_done and checks busy every cycle.
module tb_job_launcher;

  localparam int JOB_W    = 8;
  localparam int LAT_W    = 16;
  localparam int GAP_CYC  = 2;
  localparam int TMO_CYC  = 16;
  localparam int HOLD_MAX = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             go = 1'b0;
  logic [JOB_W-1:0] num_jobs = '0;
  logic             job_start;
  logic             job_done;
  logic             busy;
  logic             all_done;
  logic [JOB_W-1:0] jobs_completed;
  logic [LAT_W-1:0] last_latency;
  logic [LAT_W-1:0] max_latency;
  logic             err_timeout;

  job_launcher #(
    .JOB_W   (JOB_W),
    .LAT_W   (LAT_W),
    .GAP_CYC (GAP_CYC),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .go             (go),
    .num_jobs       (num_jobs),
    .job_start      (job_start),
    .job_done       (job_done),
    .busy           (busy),
    .all_done       (all_done),
    .jobs_completed (jobs_completed),
    .last_latency   (last_latency),
    .max_latency    (max_latency),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
    int jc;
    int last;
    int mx;
    bit err;
  } ev_t;

  ev_t sb[$];
  int  wk_lat[$];
  int  wk_hold[$];
  int  plan_lat[$];
  int  plan_hold[$];

  int n_cmp = 0;
  int n_bad = 0;
  int busy_from = 0;
  int busy_to = 0;
  int m_last = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_all_done"}, all_done, 0);
    chk({tag, "_job_start"}, job_start, 0);
    chk({tag, "_jobs_completed"}, jobs_completed, 0);
    chk({tag, "_last_latency"}, last_latency, 0);
    chk({tag, "_max_latency"}, max_latency, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // Model worker: after each job_start waits the planned delay, then holds done for the planned
  // number of cycles. A delay of 0 means the worker never answers.
  initial begin
    int lat;
    int hold;
    job_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && job_start) begin
        lat  = (wk_lat.size() > 0) ? wk_lat.pop_front() : 3;
        hold = (wk_hold.size() > 0) ? wk_hold.pop_front() : 1;
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1 job_done = 1'b1;
          repeat (hold) @(posedge clk);
          #1 job_done = 1'b0;
        end
      end
    end
  end

  task automatic handle_event(input bit is_done);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got %s at cycle %0d, expected no event",
               is_done ? "all_done" : "job_start", cyc);
    end else begin
      e = sb.pop_front();
      chk("event_kind", is_done, e.is_done);
      chk("event_cycle", cyc, e.cyc);
      if (e.is_done) begin
        chk("jobs_completed", jobs_completed, e.jc);
        chk("last_latency", last_latency, e.last);
        chk("max_latency", max_latency, e.mx);
        chk("err_timeout", err_timeout, e.err);
      end
    end
  endtask

  // Monitor: busy window every cycle, scoreboard pop on each output pulse.
  always @(negedge clk) begin
    if (reset) begin
      chk("busy", busy, (cyc >= busy_from) && (cyc < busy_to));
      if (job_start) handle_event(1'b0);
      if (all_done) handle_event(1'b1);
    end
  end

  // Expected behaviour of one batch whose go is driven in the current cycle:
  // start k at s, done seen at s+lat, done falls at s+lat+hold, next start GAP_CYC later;
  // all_done two cycles after the last done (two cycles after go for an empty batch).
  // A silent worker is timed out at TMO_CYC and its done line stays low afterwards.
  task automatic plan_batch(input int n);
    int g, s, d, ad, mx, last, eff, heff;
    bit err;
    g = cyc;
    s = g + 1;
    d = g;
    mx = 0;
    err = 1'b0;
    last = m_last;
    for (int k = 0; k < n; k++) begin
      if (plan_lat[k] == 0) begin
        eff  = TMO_CYC;
        heff = 1;
        err  = 1'b1;
      end else begin
        eff  = plan_lat[k];
        heff = plan_hold[k];
      end
      sb.push_back('{is_done: 1'b0, cyc: s, jc: 0, last: 0, mx: 0, err: 1'b0});
      wk_lat.push_back(plan_lat[k]);
      wk_hold.push_back(plan_hold[k]);
      d    = s + eff;
      last = eff;
      if (eff > mx) mx = eff;
      s = d + heff + GAP_CYC;
    end
    ad = (n == 0) ? g + 2 : d + 2;
    sb.push_back('{is_done: 1'b1, cyc: ad, jc: n, last: last, mx: mx, err: err});
    m_last    = last;
    busy_from = g + 1;
    busy_to   = ad;
  endtask

  task automatic run_batch(input int n, input bit mid_go);
    int budget;
    plan_batch(n);
    go = 1'b1;
    num_jobs = JOB_W'(n);
    step();
    go = 1'b0;
    num_jobs = JOB_W'($urandom);
    if (mid_go && n > 0) begin
      step();
      go = 1'b1;
      num_jobs = JOB_W'($urandom_range(1, 9));
      step();
      go = 1'b0;
    end
    budget = 3000;
    while (sb.size() > 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("batch_drained", sb.size(), 0);
    sb.delete();
    repeat (HOLD_MAX + 3) step();
  endtask

  initial begin
    int g, target, budget, n;

    // Power-on reset held for 100 ns.
    #50;
    chk_all_zero("reset");
    #51 reset = 1'b1;
    step();

    // Three jobs, each answered 5 cycles after start.
    plan_lat  = '{5, 5, 5};
    plan_hold = '{1, 1, 1};
    run_batch(3, 1'b0);

    // Empty batch.
    run_batch(0, 1'b0);

    // Done held high for 20 cycles: next start waits for it to fall.
    plan_lat  = '{3, 4};
    plan_hold = '{20, 1};
    run_batch(2, 1'b0);

    // Mixed latencies with a go pulse in the middle of the batch.
    plan_lat  = '{4, 9, 6};
    plan_hold = '{1, 2, 1};
    run_batch(3, 1'b1);

    // Reset while job 2 is waiting for done.
    plan_lat  = '{4, 10};
    plan_hold = '{1, 1};
    g = cyc;
    plan_batch(2);
    go = 1'b1;
    num_jobs = 8'd2;
    step();
    go = 1'b0;
    target = g + 1 + 4 + 1 + GAP_CYC + 3;
    budget = 100;
    while (cyc < target && budget > 0) begin
      step();
      budget--;
    end
    #2 reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    m_last = 0;
    busy_from = 0;
    busy_to = 0;
    repeat (15) step();
    reset = 1'b1;
    step();

    // Clean batch after the abort.
    plan_lat  = '{$urandom_range(1, 12), $urandom_range(1, 12)};
    plan_hold = '{$urandom_range(1, 4), $urandom_range(1, 4)};
    run_batch(2, 1'b0);

`ifdef JOB_LAUNCHER_TMO_EN
    // Worker never answers: both jobs time out.
    plan_lat  = '{0, 0};
    plan_hold = '{1, 1};
    run_batch(2, 1'b0);
`endif

    // Random batches.
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(0, 5);
      plan_lat.delete();
      plan_hold.delete();
      for (int k = 0; k < n; k++) begin
        plan_lat.push_back($urandom_range(1, 12));
        plan_hold.push_back($urandom_range(1, 4));
      end
      run_batch(n, 1'($urandom_range(0, 1)));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
